// File: rtl/ascensor_n_pisos.sv
// rtl/ascensor_n_pisos.sv - single-car SCAN elevator controller
//
// Latches floor calls into a pending bitmap and serves them with a SCAN
// policy: keep moving while calls lie ahead, then reverse. Produces travel
// and door timing and reports floor, direction and door status.
//
// Ports:
//   clk              system clock, all logic on the rising edge
//   rst              synchronous active-high reset
//   call_req         floor-call bitmap, bit i requests floor i (pulse or level)
//   piso             current floor (registered)
//   direccion        01 up, 10 down, 00 stopped (registered)
//   puertas_abiertas high while doors are open (registered)
//   pendientes       pending-call bitmap (registered)
//   ocupado          high in any state other than IDLE (registered)
module ascensor_n_pisos #(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 50000000,
  parameter int DOOR_CYCLES   = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    piso,
  output logic [1:0]            direccion,
  output logic                  puertas_abiertas,
  output logic [NUM_FLOORS-1:0] pendientes,
  output logic                  ocupado
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    ARRIVE    = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t state, next_state;

  // dir_up is both the travel direction and the remembered last direction
  // used to break ties when calls lie on both sides in IDLE.
  logic dir_up, next_dir_up;

  logic [31:0] travel_cnt;
  logic [31:0] door_cnt;

  logic ahead_up, ahead_dn, here;
  logic [NUM_FLOORS-1:0] clear_mask;

  always_comb begin
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pendientes[i] && (i > int'(piso))) ahead_up = 1'b1;
      if (pendientes[i] && (i < int'(piso))) ahead_dn = 1'b1;
    end
    here = pendientes[piso];
  end

  always_comb begin
    next_state  = state;
    next_dir_up = dir_up;
    case (state)
      IDLE: begin
        if (here) begin
          next_state = DOOR_OPEN;
        end else if (ahead_up && ahead_dn) begin
          next_state = MOVING;
        end else if (ahead_up) begin
          next_state  = MOVING;
          next_dir_up = 1'b1;
        end else if (ahead_dn) begin
          next_state  = MOVING;
          next_dir_up = 1'b0;
        end
      end
      MOVING: begin
        if (travel_cnt == 32'(TRAVEL_CYCLES - 1)) next_state = ARRIVE;
      end
      ARRIVE: begin
        if (here)                                next_state = DOOR_OPEN;
        else if (dir_up ? ahead_up : ahead_dn)   next_state = MOVING;
        else                                     next_state = IDLE;
      end
      DOOR_OPEN: begin
        // A call for this floor holds the doors even on the last count.
        if (!call_req[piso] && door_cnt == 32'(DOOR_CYCLES - 1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Current-floor bit is cleared on entry to and throughout DOOR_OPEN, so a
  // same-floor call while the doors are open is absorbed.
  always_comb begin
    clear_mask = '0;
    if (state == DOOR_OPEN || next_state == DOOR_OPEN) clear_mask[piso] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      dir_up           <= 1'b1;
      piso             <= '0;
      direccion        <= 2'b00;
      puertas_abiertas <= 1'b0;
      pendientes       <= '0;
      ocupado          <= 1'b0;
      travel_cnt       <= '0;
      door_cnt         <= '0;
    end else begin
      state      <= next_state;
      dir_up     <= next_dir_up;
      pendientes <= (pendientes | call_req) & ~clear_mask;

      if (state == MOVING && next_state == MOVING) travel_cnt <= travel_cnt + 32'd1;
      else                                         travel_cnt <= '0;

      if (state == MOVING && next_state == ARRIVE)
        piso <= dir_up ? piso + FLOOR_W'(1) : piso - FLOOR_W'(1);

      if (state == DOOR_OPEN && next_state == DOOR_OPEN)
        door_cnt <= call_req[piso] ? '0 : door_cnt + 32'd1;
      else
        door_cnt <= '0;

      if (next_state == MOVING || next_state == ARRIVE)
        direccion <= next_dir_up ? 2'b01 : 2'b10;
      else
        direccion <= 2'b00;

      puertas_abiertas <= (next_state == DOOR_OPEN);
      ocupado          <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_ascensor_n_pisos.sv
// tb/tb_ascensor_n_pisos.sv - self-checking bench for ascensor_n_pisos
module tb_ascensor_n_pisos;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] call_req = 4'b0000;
  logic [1:0] piso;
  logic [1:0] direccion;
  logic       puertas_abiertas;
  logic [3:0] pendientes;
  logic       ocupado;

  int n_cmp  = 0;
  int n_fail = 0;

  ascensor_n_pisos #(
    .NUM_FLOORS(4),
    .FLOOR_W(2),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .call_req(call_req),
    .piso(piso),
    .direccion(direccion),
    .puertas_abiertas(puertas_abiertas),
    .pendientes(pendientes),
    .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] call;
    logic [1:0] piso;
    logic [1:0] dir;
    logic       doors;
    logic [3:0] pend;
    logic       ocu;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] c, input logic [1:0] p, input logic [1:0] d,
                              input logic dr, input logic [3:0] pe, input logic o);
    vec_t v;
    v.call = c; v.piso = p; v.dir = d; v.doors = dr; v.pend = pe; v.ocu = o;
    vecs.push_back(v);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [1:0] p, input logic [1:0] d,
                         input logic dr, input logic [3:0] pe, input logic o);
    chk({nm, "_piso"}, 32'(piso), 32'(p));
    chk({nm, "_dir"}, 32'(direccion), 32'(d));
    chk({nm, "_doors"}, 32'(puertas_abiertas), 32'(dr));
    chk({nm, "_pend"}, 32'(pendientes), 32'(pe));
    chk({nm, "_ocu"}, 32'(ocupado), 32'(o));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    call_req = 4'($urandom);
    step(1);
    rst = 1'b0;
    call_req = 4'b0000;
  endtask

  // Continuous sanity: floor never wraps or jumps, direction never 11.
  logic [1:0] prev_piso = 2'd0;
  always @(negedge clk) begin
    if (rst) begin
      prev_piso <= 2'd0;
    end else begin
      n_cmp++;
      if (direccion === 2'b11 || $isunknown(piso) ||
          (int'(piso) - int'(prev_piso)) > 1 || (int'(prev_piso) - int'(piso)) > 1) begin
        n_fail++;
        $display("FAIL piso_bound: piso=%0d prev=%0d dir=%b", piso, prev_piso, direccion);
      end
      prev_piso <= piso;
    end
  end

  initial begin
    // Same-floor call at floor 0.
    add(4'b0001, 2'd0, 2'b00, 1'b0, 4'b0001, 1'b0);
    for (int k = 0; k < 3; k++) add(4'b0000, 2'd0, 2'b00, 1'b1, 4'b0000, 1'b1);
    add(4'b0000, 2'd0, 2'b00, 1'b0, 4'b0000, 1'b0);
    // Long trip 0 -> 3.
    add(4'b1000, 2'd0, 2'b00, 1'b0, 4'b1000, 1'b0);
    for (int k = 0; k < 4; k++) add(4'b0000, 2'd0, 2'b01, 1'b0, 4'b1000, 1'b1);
    for (int k = 0; k < 5; k++) add(4'b0000, 2'd1, 2'b01, 1'b0, 4'b1000, 1'b1);
    for (int k = 0; k < 5; k++) add(4'b0000, 2'd2, 2'b01, 1'b0, 4'b1000, 1'b1);
    add(4'b0000, 2'd3, 2'b01, 1'b0, 4'b1000, 1'b1);
    for (int k = 0; k < 3; k++) add(4'b0000, 2'd3, 2'b00, 1'b1, 4'b0000, 1'b1);
    add(4'b0000, 2'd3, 2'b00, 1'b0, 4'b0000, 1'b0);

    // Reset with random calls.
    rst = 1'b1;
    call_req = 4'($urandom);
    step(1);
    chk_all("reset", 2'd0, 2'b00, 1'b0, 4'b0000, 1'b0);
    call_req = 4'($urandom);
    step(1);
    chk_all("reset2", 2'd0, 2'b00, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    call_req = 4'b0000;

    for (int i = 0; i < vecs.size(); i++) begin
      call_req = vecs[i].call;
      step(1);
      chk_all($sformatf("vec%0d", i), vecs[i].piso, vecs[i].dir, vecs[i].doors,
              vecs[i].pend, vecs[i].ocu);
    end
    call_req = 4'b0000;

    // Door hold at floor 3: re-pulse on the second door cycle.
    call_req = 4'b1000; step(1);
    chk("hold_pend", 32'(pendientes), 32'h8);
    call_req = 4'b0000; step(1);
    chk("hold_d1", 32'(puertas_abiertas), 32'h1);
    step(1);
    call_req = 4'b1000; step(1);
    call_req = 4'b0000;
    chk("hold_absorbed", 32'(pendientes), 32'h0);
    step(1);
    chk("hold_d4", 32'(puertas_abiertas), 32'h1);
    step(1);
    chk("hold_d5", 32'(puertas_abiertas), 32'h1);
    step(1);
    chk("hold_closed", 32'(puertas_abiertas), 32'h0);
    chk("hold_idle", 32'(ocupado), 32'h0);

    // En-route pickup at floor 1 on the way to 3.
    do_reset();
    call_req = 4'b1000; step(1);
    call_req = 4'b0000; step(2);
    call_req = 4'b0010; step(1);
    call_req = 4'b0000;
    chk("enroute_pend", 32'(pendientes), 32'ha);
    step(3);
    chk_all("enroute_stop", 2'd1, 2'b00, 1'b1, 4'b1000, 1'b1);
    step(4);
    chk_all("enroute_go", 2'd1, 2'b01, 1'b0, 4'b1000, 1'b1);
    step(10);
    chk_all("enroute_end", 2'd3, 2'b00, 1'b1, 4'b0000, 1'b1);

    // SCAN preference: at floor 2 after going up, calls at 0 and 3.
    do_reset();
    call_req = 4'b0100; step(1);
    call_req = 4'b0000; step(10);
    chk_all("scan_arr2", 2'd2, 2'b01, 1'b0, 4'b0100, 1'b1);
    step(1);
    chk("scan_door2", 32'(puertas_abiertas), 32'h1);
    call_req = 4'b1001; step(1);
    call_req = 4'b0000;
    chk("scan_pend", 32'(pendientes), 32'h9);
    step(3);
    chk_all("scan_up", 2'd2, 2'b01, 1'b0, 4'b1001, 1'b1);
    step(4);
    chk("scan_at3", 32'(piso), 32'h3);
    step(1);
    chk_all("scan_door3", 2'd3, 2'b00, 1'b1, 4'b0001, 1'b1);
    step(4);
    chk("scan_down", 32'(direccion), 32'h2);
    step(15);
    chk_all("scan_door0", 2'd0, 2'b00, 1'b1, 4'b0000, 1'b1);
    step(3);
    chk("scan_idle", 32'(ocupado), 32'h0);

    // Reset while moving between floors 1 and 2.
    call_req = 4'b1000; step(1);
    call_req = 4'b0000; step(7);
    chk_all("mid_moving", 2'd1, 2'b01, 1'b0, 4'b1000, 1'b1);
    rst = 1'b1;
    call_req = 4'($urandom);
    step(1);
    chk_all("mid_reset", 2'd0, 2'b00, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    call_req = 4'b0000;
    step(2);
    chk_all("post_reset", 2'd0, 2'b00, 1'b0, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
